// File: rtl/ucarb_if.sv
// Literal/implication bus between the unit-clause arbiter, the BCP PEs and the decider.
// The master side is the arbiter; the slave side is the PE array plus decider.
interface ucarb_if #(
  parameter int NUM_PE = 4,
  parameter int LIT_W  = 8
);
  logic [NUM_PE-1:0]       bcp_imply_valid;
  logic [NUM_PE*LIT_W-1:0] bcp_imply_lit;
  logic [NUM_PE-1:0]       bcp_conflict;
  logic [NUM_PE-1:0]       bcp_newLitAccept;
  logic signed [LIT_W-1:0] ucarb2bcp_newLit;
  logic                    ucarb2bcp_newLitValid;
  logic                    bcp_halt;
  logic signed [LIT_W-1:0] dec_lit;
  logic                    dec_valid;
  logic                    dec_ready;
  logic                    conflict;
  logic                    clear_conflict;
  logic                    overflow;
  logic                    quiescent;

  modport master (
    input  bcp_imply_valid, bcp_imply_lit, bcp_conflict, bcp_newLitAccept,
    input  dec_lit, dec_valid, clear_conflict,
    output ucarb2bcp_newLit, ucarb2bcp_newLitValid, bcp_halt,
    output dec_ready, conflict, overflow, quiescent
  );

  modport slave (
    output bcp_imply_valid, bcp_imply_lit, bcp_conflict, bcp_newLitAccept,
    output dec_lit, dec_valid, clear_conflict,
    input  ucarb2bcp_newLit, ucarb2bcp_newLitValid, bcp_halt,
    input  dec_ready, conflict, overflow, quiescent
  );
endinterface

// File: rtl/ucarb.sv
// Unit-clause arbiter: captures per-PE implications, serialises them through a
// deduplicating queue and broadcasts the head to all PEs; tracks sticky conflict.
module ucarb #(
  parameter int NUM_PE = 4,
  parameter int LIT_W  = 8,
  parameter int DEPTH  = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  ucarb_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  typedef logic signed [LIT_W-1:0] lit_t;
  typedef logic [AW-1:0]           ptr_t;
  typedef logic [AW:0]             cnt_t;
  typedef logic [PW-1:0]           pe_t;

  localparam cnt_t FULL_LVL = cnt_t'(DEPTH);
  localparam cnt_t HALT_LVL = cnt_t'(DEPTH - NUM_PE);

  function automatic lit_t negate(input lit_t l);
    return -l;
  endfunction

  function automatic pe_t rr_after(input pe_t w);
    return pe_t'((int'(w) + 1) % NUM_PE);
  endfunction

  // Control state (reset) and data storage (not reset)
  logic [NUM_PE-1:0] pend_vld_q, pend_vld_d;
  lit_t              pend_lit_q [NUM_PE];
  lit_t              pend_lit_d [NUM_PE];
  lit_t              ucq_q [DEPTH];
  ptr_t              rd_ptr_q, rd_ptr_d;
  ptr_t              wr_ptr_q, wr_ptr_d;
  cnt_t              cnt_q, cnt_d;
  logic [NUM_PE-1:0] acc_q, acc_d;
  pe_t               rr_q, rr_d;
  logic              conflict_q, conflict_d;
  logic              overflow_q, overflow_d;

  lit_t              imp_lit [NUM_PE];
  logic [DEPTH-1:0]  slot_vld;
  pe_t               scan_idx;
  pe_t               win;
  logic              win_vld;
  lit_t              win_lit;
  lit_t              neg_lit;
  logic              dup_hit;
  logic              comp_hit;
  logic              ucq_empty;
  logic              ucq_full;
  logic              nlv;
  logic              deliver;
  logic              quiescent;
  logic              drain;
  logic              drain_push;
  logic              comp_set;
  logic              dec_push;
  logic              push;
  lit_t              push_lit;
  logic              ovf_set;
  logic              conf_set;

  always_comb begin
    for (int i = 0; i < NUM_PE; i++) begin
      imp_lit[i] = bus.bcp_imply_lit[i*LIT_W +: LIT_W];
    end
  end

  // A slot is live when its distance from the read pointer is below the fill count.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      slot_vld[j] = {1'b0, ptr_t'(ptr_t'(j) - rd_ptr_q)} < cnt_q;
    end
  end

  // Scanning downward leaves the first occupied entry at or after rr_q as winner.
  always_comb begin
    win_vld  = 1'b0;
    win      = '0;
    scan_idx = '0;
    for (int k = NUM_PE - 1; k >= 0; k--) begin
      scan_idx = pe_t'((int'(rr_q) + k) % NUM_PE);
      if (pend_vld_q[scan_idx]) begin
        win_vld = 1'b1;
        win     = scan_idx;
      end
    end
  end

  always_comb begin
    win_lit  = pend_lit_q[win];
    neg_lit  = negate(win_lit);
    dup_hit  = 1'b0;
    comp_hit = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if (slot_vld[j] && (ucq_q[j] == win_lit)) dup_hit  = 1'b1;
      if (slot_vld[j] && (ucq_q[j] == neg_lit)) comp_hit = 1'b1;
    end
  end

  assign ucq_empty  = (cnt_q == '0);
  assign ucq_full   = (cnt_q == FULL_LVL);
  assign nlv        = !ucq_empty && !conflict_q;
  assign deliver    = nlv && (&(acc_q | bus.bcp_newLitAccept));
  assign quiescent  = !(|pend_vld_q) && ucq_empty && !conflict_q;

  // A duplicate takes priority over a complement hit, so a repeated literal never conflicts.
  assign drain      = win_vld && !ucq_full && !conflict_q;
  assign drain_push = drain && !dup_hit && !comp_hit;
  assign comp_set   = drain && !dup_hit && comp_hit;
  assign dec_push   = bus.dec_valid && quiescent && (bus.dec_lit != '0);
  assign push       = drain_push || dec_push;
  assign push_lit   = dec_push ? bus.dec_lit : win_lit;
  assign conf_set   = (|bus.bcp_conflict) || comp_set;

  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_lit_d = pend_lit_q;
    ovf_set    = 1'b0;
    if (conflict_q) begin
      pend_vld_d = '0;
    end else begin
      if (drain) pend_vld_d[win] = 1'b0;
      for (int i = 0; i < NUM_PE; i++) begin
        if (bus.bcp_imply_valid[i] && (imp_lit[i] != '0)) begin
          if (pend_vld_d[i]) begin
            ovf_set = 1'b1;
          end else begin
            pend_vld_d[i] = 1'b1;
            pend_lit_d[i] = imp_lit[i];
          end
        end
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rr_d     = rr_q;
    if (conflict_q) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      acc_d    = '0;
    end else begin
      if (push)    wr_ptr_d = wr_ptr_q + 1'b1;
      if (deliver) rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + cnt_t'(push) - cnt_t'(deliver);
      if (deliver)  acc_d = '0;
      else if (nlv) acc_d = acc_q | bus.bcp_newLitAccept;
      if (drain)    rr_d  = rr_after(win);
    end
  end

  always_comb begin
    conflict_d = conflict_q;
    overflow_d = overflow_q;
    if (conf_set)                conflict_d = 1'b1;
    else if (bus.clear_conflict) conflict_d = 1'b0;
    if (ovf_set)                 overflow_d = 1'b1;
    else if (bus.clear_conflict) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pend_vld_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      rr_q       <= '0;
      conflict_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pend_vld_q <= pend_vld_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      rr_q       <= rr_d;
      conflict_q <= conflict_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_lit_q <= pend_lit_d;
    if (push) ucq_q[wr_ptr_q] <= push_lit;
  end

  assign bus.ucarb2bcp_newLitValid = nlv;
  assign bus.ucarb2bcp_newLit      = ucq_empty ? '0 : ucq_q[rd_ptr_q];
  assign bus.bcp_halt              = (cnt_q >= HALT_LVL) || conflict_q;
  assign bus.dec_ready             = quiescent;
  assign bus.quiescent             = quiescent;
  assign bus.conflict              = conflict_q;
  assign bus.overflow              = overflow_q;

endmodule

// File: tb/tb_ucarb.sv
// Bench for ucarb: directed scenarios plus randomized traffic against a queue-based model.
module tb_ucarb;
  localparam int NUM_PE = 4;
  localparam int LIT_W  = 8;
  localparam int DEPTH  = 16;
  typedef logic signed [LIT_W-1:0] lit_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ucarb_if #(.NUM_PE(NUM_PE), .LIT_W(LIT_W)) bus ();
  ucarb #(.NUM_PE(NUM_PE), .LIT_W(LIT_W), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: pending slots, UCQ as a plain queue of literals.
  bit                m_pv [NUM_PE];
  lit_t              m_pl [NUM_PE];
  lit_t              m_q [$];
  logic [NUM_PE-1:0] m_acc;
  int                m_rr;
  bit                m_conf, m_ovf;

  function automatic bit m_nlv();   return (m_q.size() != 0) && !m_conf; endfunction
  function automatic lit_t m_lit(); return (m_q.size() != 0) ? m_q[0] : lit_t'(0); endfunction
  function automatic bit m_halt();  return (m_q.size() >= DEPTH - NUM_PE) || m_conf; endfunction
  function automatic bit m_quiet();
    bit any = 0;
    for (int i = 0; i < NUM_PE; i++) if (m_pv[i]) any = 1;
    return !any && (m_q.size() == 0) && !m_conf;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_PE; i++) begin m_pv[i] = 0; m_pl[i] = '0; end
    m_q.delete(); m_acc = '0; m_rr = 0; m_conf = 0; m_ovf = 0;
  endtask

  task automatic model_edge();
    bit nlv, deliver, quiet, conf_set, ovf_set, push, found, dup, comp;
    lit_t push_l, w_l, neg, il;
    int w;
    nlv      = m_nlv();
    deliver  = nlv && ((m_acc | bus.bcp_newLitAccept) == {NUM_PE{1'b1}});
    quiet    = m_quiet();
    conf_set = |bus.bcp_conflict;
    ovf_set = 0; push = 0; push_l = '0; found = 0; w = 0;
    if (m_conf) begin
      m_q.delete();
      for (int i = 0; i < NUM_PE; i++) m_pv[i] = 0;
      m_acc = '0;
    end else begin
      for (int k = 0; k < NUM_PE; k++)
        if (!found && m_pv[(m_rr + k) % NUM_PE]) begin found = 1; w = (m_rr + k) % NUM_PE; end
      if (found && m_q.size() < DEPTH) begin
        w_l = m_pl[w]; neg = -w_l; m_pv[w] = 0; m_rr = (w + 1) % NUM_PE;
        dup = 0; comp = 0;
        foreach (m_q[j]) begin
          if (m_q[j] == w_l) dup = 1;
          if (m_q[j] == neg) comp = 1;
        end
        if (!dup && comp) conf_set = 1;
        else if (!dup) begin push = 1; push_l = w_l; end
      end
      for (int i = 0; i < NUM_PE; i++) begin
        il = bus.bcp_imply_lit[i*LIT_W +: LIT_W];
        if (bus.bcp_imply_valid[i] && il != 0) begin
          if (m_pv[i]) ovf_set = 1;
          else begin m_pv[i] = 1; m_pl[i] = il; end
        end
      end
      if (bus.dec_valid && quiet && bus.dec_lit != 0) begin push = 1; push_l = bus.dec_lit; end
      if (deliver) begin m_acc = '0; m_q.delete(0); end
      else if (nlv) m_acc = m_acc | bus.bcp_newLitAccept;
      if (push) m_q.push_back(push_l);
    end
    if (conf_set) m_conf = 1; else if (bus.clear_conflict) m_conf = 0;
    if (ovf_set)  m_ovf  = 1; else if (bus.clear_conflict) m_ovf  = 0;
  endtask

  task automatic idle();
    bus.bcp_imply_valid = '0; bus.bcp_imply_lit = '0; bus.bcp_conflict = '0;
    bus.bcp_newLitAccept = '0; bus.dec_lit = '0; bus.dec_valid = 1'b0; bus.clear_conflict = 1'b0;
  endtask

  task automatic set_imply(input int pe, input lit_t l);
    bus.bcp_imply_valid[pe] = 1'b1;
    bus.bcp_imply_lit[pe*LIT_W +: LIT_W] = l;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle(); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; model_reset();
  endtask

  task automatic test_reset();
    idle(); rst_n = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    checks++; if (bus.conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b want 0", bus.conflict); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
    checks++; if (bus.ucarb2bcp_newLitValid !== 1'b0) begin errors++; $display("FAIL reset_nlv: got %b want 0", bus.ucarb2bcp_newLitValid); end
    checks++; if (bus.ucarb2bcp_newLit !== 8'sd0) begin errors++; $display("FAIL reset_newlit: got %0d want 0", bus.ucarb2bcp_newLit); end
    checks++; if (bus.bcp_halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b want 0", bus.bcp_halt); end
    checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL reset_dec_ready: got %b want 1", bus.dec_ready); end
    checks++; if (bus.quiescent !== 1'b1) begin errors++; $display("FAIL reset_quiescent: got %b want 1", bus.quiescent); end
    @(negedge clk); rst_n = 1'b0; model_reset();
  endtask

  task automatic test_single_imply();
    do_reset();
    set_imply(0, 8'sd5); tick(); idle(); #1;
    checks++; if (bus.ucarb2bcp_newLitValid !== 1'b0) begin errors++; $display("FAIL single_c1_nlv: got %b want 0", bus.ucarb2bcp_newLitValid); end
    checks++; if (bus.quiescent !== 1'b0) begin errors++; $display("FAIL single_c1_quiescent: got %b want 0", bus.quiescent); end
    tick(); bus.bcp_newLitAccept = '1; #1;
    checks++; if (bus.ucarb2bcp_newLitValid !== 1'b1) begin errors++; $display("FAIL single_c2_nlv: got %b want 1", bus.ucarb2bcp_newLitValid); end
    checks++; if (bus.ucarb2bcp_newLit !== 8'sd5) begin errors++; $display("FAIL single_c2_lit: got %0d want 5", bus.ucarb2bcp_newLit); end
    tick(); idle(); #1;
    checks++; if (bus.ucarb2bcp_newLitValid !== 1'b0) begin errors++; $display("FAIL single_c3_nlv: got %b want 0", bus.ucarb2bcp_newLitValid); end
    checks++; if (bus.quiescent !== 1'b1) begin errors++; $display("FAIL single_c3_quiescent: got %b want 1", bus.quiescent); end
  endtask

  task automatic test_staggered_accept();
    do_reset();
    set_imply(0, 8'sd3); tick(); idle(); tick();
    bus.bcp_newLitAccept = 4'b0011; tick();
    bus.bcp_newLitAccept = 4'b0000; tick();
    bus.bcp_newLitAccept = 4'b0100; tick();
    bus.bcp_newLitAccept = 4'b0000; #1;
    checks++; if (bus.ucarb2bcp_newLitValid !== 1'b1) begin errors++; $display("FAIL stagger_c5_nlv: got %b want 1", bus.ucarb2bcp_newLitValid); end
    tick(); bus.bcp_newLitAccept = 4'b1000; #1;
    checks++; if (bus.ucarb2bcp_newLitValid !== 1'b1 || bus.ucarb2bcp_newLit !== 8'sd3) begin errors++;
      $display("FAIL stagger_c6_head: got vld=%b lit=%0d want vld=1 lit=3", bus.ucarb2bcp_newLitValid, bus.ucarb2bcp_newLit); end
    tick(); idle(); #1;
    checks++; if (bus.ucarb2bcp_newLitValid !== 1'b0) begin errors++; $display("FAIL stagger_c7_nlv: got %b want 0", bus.ucarb2bcp_newLitValid); end
  endtask

  task automatic test_simultaneous();
    lit_t got [3];
    int   n = 0;
    do_reset();
    for (int i = 0; i < 3; i++) got[i] = '0;
    set_imply(0, 8'sd1); set_imply(1, 8'sd2); set_imply(2, 8'sd2); set_imply(3, 8'sd4);
    tick(); idle();
    repeat (5) tick();
    #1;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL simul_overflow: got %b want 0", bus.overflow); end
    checks++; if (bus.ucarb2bcp_newLit !== 8'sd1) begin errors++; $display("FAIL simul_head: got %0d want 1", bus.ucarb2bcp_newLit); end
    bus.bcp_newLitAccept = '1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus.ucarb2bcp_newLitValid === 1'b1) begin
        if (n < 3) got[n] = bus.ucarb2bcp_newLit;
        n++;
      end
      tick();
    end
    idle();
    checks++; if (n != 3) begin errors++; $display("FAIL simul_count: got %0d broadcasts want 3", n); end
    checks++; if (got[0] !== 8'sd1 || got[1] !== 8'sd2 || got[2] !== 8'sd4) begin errors++;
      $display("FAIL simul_order: got %0d,%0d,%0d want 1,2,4", got[0], got[1], got[2]); end
  endtask

  task automatic test_complement();
    do_reset();
    set_imply(0, 8'sd7); tick(); idle(); tick();
    set_imply(1, -8'sd7); tick(); idle(); tick(); #1;
    checks++; if (bus.conflict !== 1'b1) begin errors++; $display("FAIL comp_conflict: got %b want 1", bus.conflict); end
    checks++; if (bus.ucarb2bcp_newLitValid !== 1'b0) begin errors++; $display("FAIL comp_nlv: got %b want 0", bus.ucarb2bcp_newLitValid); end
    checks++; if (bus.bcp_halt !== 1'b1) begin errors++; $display("FAIL comp_halt: got %b want 1", bus.bcp_halt); end
    tick(); #1;
    checks++; if (bus.quiescent !== 1'b0) begin errors++; $display("FAIL comp_quiescent_held: got %b want 0", bus.quiescent); end
    bus.clear_conflict = 1'b1; tick(); idle(); #1;
    checks++; if (bus.conflict !== 1'b0) begin errors++; $display("FAIL comp_cleared: got %b want 0", bus.conflict); end
    checks++; if (bus.quiescent !== 1'b1 || bus.bcp_halt !== 1'b0) begin errors++;
      $display("FAIL comp_flushed: got quiescent=%b halt=%b want 1,0", bus.quiescent, bus.bcp_halt); end
  endtask

  task automatic test_backpressure();
    lit_t exp_q [$];
    lit_t got_q [$];
    do_reset();
    for (int i = 0; i < 11; i++) begin set_imply(0, lit_t'(10 + i)); exp_q.push_back(lit_t'(10 + i)); tick(); end
    idle(); tick(); tick(); #1;
    checks++; if (bus.bcp_halt !== 1'b0) begin errors++; $display("FAIL bp_halt_below: got %b want 0 at 11 entries", bus.bcp_halt); end
    set_imply(0, 8'sd21); exp_q.push_back(8'sd21); tick(); idle(); tick(); #1;
    checks++; if (bus.bcp_halt !== 1'b1) begin errors++; $display("FAIL bp_halt_at: got %b want 1 at 12 entries", bus.bcp_halt); end
    for (int i = 0; i < 4; i++) begin set_imply(0, lit_t'(30 + i)); exp_q.push_back(lit_t'(30 + i)); tick(); end
    idle(); tick(); tick();
    set_imply(0, 8'sd40); exp_q.push_back(8'sd40); tick();
    set_imply(0, 8'sd41); #1;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL bp_no_early_overflow: got %b want 0", bus.overflow); end
    tick(); idle(); #1;
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow: got %b want 1", bus.overflow); end
    bus.bcp_newLitAccept = '1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.ucarb2bcp_newLitValid === 1'b1) got_q.push_back(bus.ucarb2bcp_newLit);
      tick();
    end
    idle();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_drain_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_drain_order[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]); end
    end
    #1;
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow_sticky: got %b want 1", bus.overflow); end
    bus.clear_conflict = 1'b1; tick(); idle(); #1;
    checks++; if (bus.overflow !== 1'b0 || bus.quiescent !== 1'b1) begin errors++;
      $display("FAIL bp_clear: got overflow=%b quiescent=%b want 0,1", bus.overflow, bus.quiescent); end
  endtask

  task automatic test_decision();
    do_reset();
    bus.dec_lit = -8'sd9; bus.dec_valid = 1'b1; #1;
    checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL dec_ready_idle: got %b want 1", bus.dec_ready); end
    tick(); idle(); #1;
    checks++; if (bus.ucarb2bcp_newLitValid !== 1'b1 || bus.ucarb2bcp_newLit !== -8'sd9) begin errors++;
      $display("FAIL dec_broadcast: got vld=%b lit=%0d want vld=1 lit=-9", bus.ucarb2bcp_newLitValid, bus.ucarb2bcp_newLit); end
    bus.bcp_newLitAccept = '1; tick(); idle();
    set_imply(2, 8'sd6); tick(); idle();
    bus.dec_lit = 8'sd11; bus.dec_valid = 1'b1; #1;
    checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL dec_ready_pending: got %b want 0", bus.dec_ready); end
    tick(); idle(); #1;
    checks++; if (bus.ucarb2bcp_newLit !== 8'sd6) begin errors++; $display("FAIL dec_blocked_head: got %0d want 6", bus.ucarb2bcp_newLit); end
    #2 rst_n = 1'b1; #1;
    checks++; if (bus.ucarb2bcp_newLitValid !== 1'b0 || bus.ucarb2bcp_newLit !== 8'sd0) begin errors++;
      $display("FAIL async_reset_bcast: got vld=%b lit=%0d want 0,0", bus.ucarb2bcp_newLitValid, bus.ucarb2bcp_newLit); end
    checks++; if (bus.dec_ready !== 1'b1 || bus.quiescent !== 1'b1 || bus.bcp_halt !== 1'b0) begin errors++;
      $display("FAIL async_reset_ctrl: got ready=%b quiescent=%b halt=%b want 1,1,0", bus.dec_ready, bus.quiescent, bus.bcp_halt); end
    @(negedge clk); rst_n = 1'b0; model_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      idle();
      for (int i = 0; i < NUM_PE; i++) begin
        if ($urandom_range(3) == 0) set_imply(i, lit_t'(int'($urandom_range(12)) - 6));
      end
      bus.bcp_newLitAccept = NUM_PE'($urandom);
      if ($urandom_range(5) != 0) bus.bcp_newLitAccept = bus.bcp_newLitAccept | NUM_PE'($urandom);
      if ($urandom_range(99) == 0) bus.bcp_conflict[$urandom_range(NUM_PE-1)] = 1'b1;
      bus.clear_conflict = ($urandom_range(7) == 0);
      bus.dec_valid = ($urandom_range(2) == 0);
      bus.dec_lit = lit_t'(int'($urandom_range(12)) - 6);
      #1;
      checks++; if (bus.ucarb2bcp_newLitValid !== m_nlv()) begin errors++; $display("FAIL rnd_nlv c%0d: got %b want %b", c, bus.ucarb2bcp_newLitValid, m_nlv()); end
      checks++; if (bus.ucarb2bcp_newLit !== m_lit()) begin errors++; $display("FAIL rnd_lit c%0d: got %0d want %0d", c, bus.ucarb2bcp_newLit, m_lit()); end
      checks++; if (bus.bcp_halt !== m_halt()) begin errors++; $display("FAIL rnd_halt c%0d: got %b want %b", c, bus.bcp_halt, m_halt()); end
      checks++; if (bus.quiescent !== m_quiet()) begin errors++; $display("FAIL rnd_quiescent c%0d: got %b want %b", c, bus.quiescent, m_quiet()); end
      checks++; if (bus.dec_ready !== m_quiet()) begin errors++; $display("FAIL rnd_dec_ready c%0d: got %b want %b", c, bus.dec_ready, m_quiet()); end
      checks++; if (bus.conflict !== m_conf) begin errors++; $display("FAIL rnd_conflict c%0d: got %b want %b", c, bus.conflict, m_conf); end
      checks++; if (bus.overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow c%0d: got %b want %b", c, bus.overflow, m_ovf); end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_single_imply();
    test_staggered_accept();
    test_simultaneous();
    test_complement();
    test_backpressure();
    test_decision();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete within 500000 time units");
    $fatal(1);
  end

endmodule

// File: doc/ucarb.md
Name: ucarb

Overview:
- Unit-clause arbiter: the producer end of the BCP PE literal interface and the consumer end of its implication/conflict outputs.
- Each cycle it captures implications from NUM_PE BCP PEs and serialises them through a deduplicating unit-clause queue (UCQ).
- It broadcasts the queue head to all PEs under a valid/accept handshake and raises a sticky conflict.
- It also accepts decision literals from the decider when the BCP round has drained.

Parameters:
- NUM_PE, 4, number of BCP PEs served.
- LIT_W, 8, literal width in bits: 2's-complement signed index, 0 reserved (= lit_t width).
- DEPTH, 16, UCQ entries; power of two, at least 2*NUM_PE.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-high despite the name.
- bcp_imply_valid  in  NUM_PE  per-PE implication strobe; single cycle, not held.
- bcp_imply_lit  in  NUM_PE*LIT_W  per-PE implied literal.
- bcp_conflict  in  NUM_PE  per-PE conflict strobe.
- bcp_newLitAccept  in  NUM_PE  per-PE accept of the broadcast literal.
- ucarb2bcp_newLit  out  LIT_W  broadcast literal; equals the UCQ head.
- ucarb2bcp_newLitValid  out  1  broadcast valid.
- bcp_halt  out  1  stall request to all PEs.
- dec_lit  in  LIT_W  decision literal.
- dec_valid  in  1  decision valid.
- dec_ready  out  1  decision accepted when dec_valid & dec_ready.
- conflict  out  1  sticky conflict.
- clear_conflict  in  1  clears conflict; single cycle.
- overflow  out  1  sticky error: an implication was lost.
- quiescent  out  1  pending empty, UCQ empty, no broadcast in flight, no conflict.

Behaviour:
- Reset (async, on rst_n=1):
  - pending regs, UCQ pointers/count, accept mask, RR pointer -> 0.
  - conflict=0, overflow=0, newLitValid=0, newLit=0, bcp_halt=0, dec_ready=1, quiescent=1.
  - Reset mid-broadcast drops all literals.
- Capture:
  - At each posedge, for PE i with imply_valid[i]=1 and imply_lit[i]!=0, load pending[i] (valid+lit).
  - If pending[i] is still occupied and not drained that same cycle, the new literal is dropped and overflow is set.
  - lit==0 is ignored.
- Drain:
  - Round-robin across pending entries, starting at RR pointer; at most one per cycle.
  - RR pointer advances to winner+1 mod NUM_PE.
  - A winner is drained only if UCQ is not full. If full, pending holds and nothing is dropped.
- Dedup and complement check:
  - The winner literal L is compared against all valid UCQ entries, including the head being broadcast.
  - L already present: pending is cleared, nothing is enqueued.
  - -L present: conflict is set, no enqueue.
- Latency: imply strobe in cycle t -> pending at t+1 -> UCQ write at the end of t+1 -> newLitValid in cycle t+2 if UCQ was empty.
- Broadcast:
  - newLitValid = UCQ nonempty & !conflict.
  - acc_mask[i] sets when newLitValid & bcp_newLitAccept[i].
  - Delivery completes in the cycle when (acc_mask | bcp_newLitAccept) is all ones. The head pops at that edge and acc_mask clears.
  - The next head is valid the following cycle, so there is at least one cycle between distinct literals.
- Halt: bcp_halt = (UCQ count >= DEPTH-NUM_PE) | conflict. Registered-free, combinational from state.
- Decision path:
  - dec_ready = quiescent. This is combinational, and quiescent is true only once all pending entries are empty.
  - On dec_valid & dec_ready, dec_lit is written to the UCQ as a normal entry; it is broadcast at t+1.
  - dec_lit == 0 is ignored.
- Conflict:
  - Set by any bcp_conflict[i] or by the complement check.
  - While set: UCQ and pending are flushed next cycle, acc_mask clears, newLitValid=0, further implications are ignored.
  - clear_conflict clears conflict and overflow at the next edge.
  - Simultaneous set and clear: set wins.
- Simultaneous events:
  - Pop and push in the same cycle are both performed; count is unchanged.
  - A drained L equal to the head popping that cycle is still treated as duplicate (dropped).
- Pointers wrap mod DEPTH.
- Signed compare for negation: -L is LIT_W-bit 2's complement.

Test Plan:
- Single imply: PE0 imply +5 at cycle 0, all PEs accept at cycle 2 -> newLit=5 valid at cycle 2; popped; quiescent=1 at cycle 3.
- Staggered accept: head +3; PE0/PE1 accept at cycle 2, PE2 at 4, PE3 at 6 -> newLitValid held through cycle 6; pop at the cycle-6 edge.
- Simultaneous imply: PE0..3 imply +1,+2,+2,+4 in one cycle -> UCQ receives 1,2,4 in RR order over 4 drain cycles; duplicate +2 dropped, no overflow.
- Complement: UCQ holds +7, PE1 implies -7 -> conflict=1, newLitValid=0, UCQ flushed, bcp_halt=1; clear_conflict -> quiescent=1.
- Backpressure: fill UCQ to DEPTH-NUM_PE -> bcp_halt=1. PE0 strobes twice without a drain while UCQ is full -> overflow=1, first literal retained.
- Decision: quiescent, dec_lit=-9 dec_valid=1 -> dec_ready=1, newLit=-9 valid next cycle. With pending nonempty -> dec_ready=0. Assert rst_n mid-broadcast -> all outputs at reset values immediately.
